// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm state machine downstream of the time/alarm comparator.
// It rings on a qualified match pulse and times the ring and snooze periods
// from the 1 Hz sec_tick strobe. It also handles bounded snoozes and user stop.
// All outputs are decoded from registers only.
module alarm_ctrl #(
    parameter int RING_TIMEOUT_S = 60,   // 1..1023
    parameter int SNOOZE_S       = 300,  // 1..1023
    parameter int MAX_SNOOZE     = 3     // 0..3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       H,
    input  logic       sec_tick,
    input  logic       en,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       buzz,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] state,
    output logic [1:0] snooze_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2,
        ST_BAD     = 2'd3
    } state_t;

    // Terminal counts: the timer runs 0..N-1, so the tick seen at N-1 ends the period.
    localparam logic [9:0] RING_LAST   = 10'(RING_TIMEOUT_S - 1);
    localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_S - 1);
    localparam logic [1:0] SNOOZE_MAX  = 2'(MAX_SNOOZE);

    state_t     state_reg, state_next;
    logic [9:0] timer_reg, timer_next;
    logic [1:0] snooze_cnt_reg, snooze_cnt_next;
    logic       beep_phase_reg, beep_phase_next;

    // State register; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            timer_reg      <= 10'd0;
            snooze_cnt_reg <= 2'd0;
            beep_phase_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            snooze_cnt_reg <= snooze_cnt_next;
            beep_phase_reg <= beep_phase_next;
        end
    end

    // Next-state logic. Within each active state, earlier branches take priority.
    // Every return to IDLE clears the whole event context.
    always_comb begin
        state_next      = state_reg;
        timer_next      = timer_reg;
        snooze_cnt_next = snooze_cnt_reg;
        beep_phase_next = beep_phase_reg;

        case (state_reg)
            ST_IDLE: begin
                // A match while disarmed is dropped; buttons and ticks do nothing here.
                if (H && en) begin
                    state_next      = ST_RINGING;
                    timer_next      = 10'd0;
                    snooze_cnt_next = 2'd0;
                    beep_phase_next = 1'b1;
                end
            end

            ST_RINGING: begin
                if (!en || stop_btn) begin
                    state_next      = ST_IDLE;
                    timer_next      = 10'd0;
                    snooze_cnt_next = 2'd0;
                    beep_phase_next = 1'b0;
                end else if (snooze_btn && (snooze_cnt_reg < SNOOZE_MAX)) begin
                    // This snooze outranks a timeout tick that arrives in the same cycle.
                    state_next      = ST_SNOOZE;
                    timer_next      = 10'd0;
                    snooze_cnt_next = snooze_cnt_reg + 2'd1;
                end else if (sec_tick) begin
                    if (timer_reg == RING_LAST) begin
                        state_next      = ST_IDLE;
                        timer_next      = 10'd0;
                        snooze_cnt_next = 2'd0;
                        beep_phase_next = 1'b0;
                    end else begin
                        timer_next      = timer_reg + 10'd1;
                        beep_phase_next = ~beep_phase_reg;
                    end
                end
            end

            ST_SNOOZE: begin
                if (!en || stop_btn) begin
                    state_next      = ST_IDLE;
                    timer_next      = 10'd0;
                    snooze_cnt_next = 2'd0;
                    beep_phase_next = 1'b0;
                end else if (sec_tick) begin
                    if (timer_reg == SNOOZE_LAST) begin
                        // Ringing restarts with the buzzer on, with a fresh ring timer.
                        state_next      = ST_RINGING;
                        timer_next      = 10'd0;
                        beep_phase_next = 1'b1;
                    end else begin
                        timer_next = timer_reg + 10'd1;
                    end
                end
            end

            default: begin
                // Recover from the unused encoding on the next clock.
                state_next      = ST_IDLE;
                timer_next      = 10'd0;
                snooze_cnt_next = 2'd0;
                beep_phase_next = 1'b0;
            end
        endcase
    end

    // Output decode from registers only.
    assign ringing    = (state_reg == ST_RINGING);
    assign snoozing   = (state_reg == ST_SNOOZE);
    assign buzz       = (state_reg == ST_RINGING) && beep_phase_reg;
    assign state      = state_reg;
    assign snooze_cnt = snooze_cnt_reg;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed scoreboard bench for alarm_ctrl.
// The stimulus pushes hand-computed expected outputs, each tagged with a target cycle.
// A separate monitor pops and compares them on the falling edge of that cycle.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       H, sec_tick, en, snooze_btn, stop_btn;
    logic       buzz, ringing, snoozing;
    logic [1:0] state, snooze_cnt;

    alarm_ctrl #(
        .RING_TIMEOUT_S(4),
        .SNOOZE_S      (3),
        .MAX_SNOOZE    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .H         (H),
        .sec_tick  (sec_tick),
        .en        (en),
        .snooze_btn(snooze_btn),
        .stop_btn  (stop_btn),
        .buzz      (buzz),
        .ringing   (ringing),
        .snoozing  (snoozing),
        .state     (state),
        .snooze_cnt(snooze_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       bz;
        logic [1:0] sc;
        string      name;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;
    int  n_vec  = 0;
    int  n_fail = 0;

    // Monitor: compare every entry whose target cycle has arrived.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            n_vec++;
            if (mon_e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: entry for cycle %0d reached at cycle %0d", mon_e.name, mon_e.cyc, cyc);
            end else if ({state, ringing, snoozing, buzz, snooze_cnt} !==
                         {mon_e.st, mon_e.st == 2'd1, mon_e.st == 2'd2, mon_e.bz, mon_e.sc}) begin
                n_fail++;
                $display("FAIL %s: got state=%0d ringing=%0b snoozing=%0b buzz=%0b snooze_cnt=%0d, want state=%0d ringing=%0b snoozing=%0b buzz=%0b snooze_cnt=%0d",
                         mon_e.name, state, ringing, snoozing, buzz, snooze_cnt,
                         mon_e.st, mon_e.st == 2'd1, mon_e.st == 2'd2, mon_e.bz, mon_e.sc);
            end else begin
                $display("check %-16s cyc=%0d state=%0d buzz=%0b snooze_cnt=%0d ok",
                         mon_e.name, cyc, state, buzz, snooze_cnt);
            end
        end
    end

    // Expect these outputs after the next clock edge (i.e. after the next step).
    task automatic expect_next(input string name, input logic [1:0] st,
                               input logic bz, input logic [1:0] sc);
        sb_t e;
        e.cyc = cyc + 1;
        e.st = st;
        e.bz = bz;
        e.sc = sc;
        e.name = name;
        sb.push_back(e);
    endtask

    // One clock with the given one-cycle pulses; called and returning on a falling edge.
    task automatic step(input logic h, input logic tk, input logic snz, input logic stp);
        H = h;
        sec_tick = tk;
        snooze_btn = snz;
        stop_btn = stp;
        @(negedge clk);
        H = 1'b0;
        sec_tick = 1'b0;
        snooze_btn = 1'b0;
        stop_btn = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Nine quiet clocks followed by a tick: one second at ten clocks per tick.
    task automatic second_tick(input string name, input logic [1:0] st,
                               input logic bz, input logic [1:0] sc);
        idle(9);
        expect_next(name, st, bz, sc);
        step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        H = 1'b0;
        sec_tick = 1'b0;
        snooze_btn = 1'b0;
        stop_btn = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        expect_next("reset", 2'd0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Basic ring and timeout: buzz 1,0,1,0 and idle after the 4th tick
        en = 1'b1;
        expect_next("ring_entry", 2'd1, 1'b1, 2'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        expect_next("ring_midsec", 2'd1, 1'b1, 2'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        expect_next("ring_tick1", 2'd1, 1'b0, 2'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        second_tick("ring_tick2", 2'd1, 1'b1, 2'd0);
        second_tick("ring_tick3", 2'd1, 1'b0, 2'd0);
        second_tick("ring_timeout", 2'd0, 1'b0, 2'd0);

        // Snooze cycle
        expect_next("snz_entry", 2'd1, 1'b1, 2'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        second_tick("snz_tick1", 2'd1, 1'b0, 2'd0);
        expect_next("snz_press1", 2'd2, 1'b0, 2'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        second_tick("snz_s1", 2'd2, 1'b0, 2'd1);
        second_tick("snz_s2", 2'd2, 1'b0, 2'd1);
        second_tick("snz_rering1", 2'd1, 1'b1, 2'd1);

        // Snooze limit
        expect_next("snz_press2", 2'd2, 1'b0, 2'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        second_tick("lim_s1", 2'd2, 1'b0, 2'd2);
        second_tick("lim_s2", 2'd2, 1'b0, 2'd2);
        second_tick("lim_rering2", 2'd1, 1'b1, 2'd2);
        expect_next("lim_press3", 2'd1, 1'b1, 2'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        second_tick("lim_tick1", 2'd1, 1'b0, 2'd2);
        second_tick("lim_tick2", 2'd1, 1'b1, 2'd2);
        second_tick("lim_tick3", 2'd1, 1'b0, 2'd2);
        second_tick("lim_timeout", 2'd0, 1'b0, 2'd0);

        // Stop beats snooze
        expect_next("stp_entry", 2'd1, 1'b1, 2'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        expect_next("stop_vs_snooze", 2'd0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1);

        // Snooze beats the timeout tick
        expect_next("pri_entry", 2'd1, 1'b1, 2'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        second_tick("pri_tick1", 2'd1, 1'b0, 2'd0);
        second_tick("pri_tick2", 2'd1, 1'b1, 2'd0);
        second_tick("pri_tick3", 2'd1, 1'b0, 2'd0);
        idle(9);
        expect_next("snooze_vs_tmo", 2'd2, 1'b0, 2'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        expect_next("pri_stop", 2'd0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Disarmed match is dropped
        en = 1'b0;
        expect_next("h_disarmed", 2'd0, 1'b0, 2'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        en = 1'b1;

        // H during snooze leaves the timer alone: the 3rd snooze tick still re-rings
        expect_next("ign_entry", 2'd1, 1'b1, 2'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        expect_next("ign_snooze", 2'd2, 1'b0, 2'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        second_tick("ign_s1", 2'd2, 1'b0, 2'd1);
        idle(4);
        expect_next("h_in_snooze", 2'd2, 1'b0, 2'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        expect_next("ign_s2", 2'd2, 1'b0, 2'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        second_tick("ign_rering", 2'd1, 1'b1, 2'd1);

        // Enable dropped in snooze
        expect_next("en_snooze", 2'd2, 1'b0, 2'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        en = 1'b0;
        expect_next("en_drop", 2'd0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'b1;

        // Reset mid-ring with buzz=1 and snooze_cnt=1
        expect_next("rst_entry", 2'd1, 1'b1, 2'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        expect_next("rst_snooze", 2'd2, 1'b0, 2'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        second_tick("rst_s1", 2'd2, 1'b0, 2'd1);
        second_tick("rst_s2", 2'd2, 1'b0, 2'd1);
        second_tick("rst_rering", 2'd1, 1'b1, 2'd1);
        rst = 1'b1;
        expect_next("rst_mid", 2'd0, 1'b0, 2'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        expect_next("post_rst_ring", 2'd1, 1'b1, 2'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        second_tick("post_rst_tick", 2'd1, 1'b0, 2'd0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries never checked, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
